// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
// encoder_pkg : shared types and helpers for onehot_stream_encoder
// Rev 1.0
// ============================================================================
package encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_e;

  // Population count over the widest legal request vector.
  function automatic int unsigned popcount(input logic [255:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 256; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_stream_encoder_ffs.sv
`default_nettype none
// ============================================================================
// find_first_set : lowest set-bit index, any-set and exactly-one-set flags
// Rev 1.0
// ============================================================================
module find_first_set #(
  parameter int NUM_WIRE = 4
) (
  input  logic [NUM_WIRE-1:0]         vec_i,
  output logic [$clog2(NUM_WIRE)-1:0] idx_o,
  output logic                        found_o,
  output logic                        single_o
);

  localparam int A_W = $clog2(NUM_WIRE);

  logic [NUM_WIRE-1:0] w_minus_one;

  assign w_minus_one = vec_i - NUM_WIRE'(1);

  // Scan from the top down so the lowest set bit is the last assignment to win.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_WIRE - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = A_W'(i);
      end
    end
  end

  assign found_o  = |vec_i;
  assign single_o = found_o && ((vec_i & w_minus_one) == '0);

endmodule
`default_nettype wire

// File: rtl/onehot_stream_encoder.sv
`default_nettype none
// ============================================================================
// onehot_stream_encoder : streams the index of every set request bit, lowest first
// Rev 1.0
// ============================================================================
module onehot_stream_encoder
  import encoder_pkg::*;
#(
  parameter int NUM_WIRE = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_WIRE-1:0]         d_i,
  input  logic                        d_valid_i,
  output logic                        d_ready_o,
  output logic [$clog2(NUM_WIRE)-1:0] a_o,
  output logic                        a_valid_o,
  input  logic                        a_ready_i,
  output logic                        a_last_o,
  output logic                        busy_o
);

  localparam int A_W = $clog2(NUM_WIRE);

  enc_state_e          r_state;
  enc_state_e          w_state_nxt;
  logic [NUM_WIRE-1:0] r_pending;
  logic [NUM_WIRE-1:0] w_pending_nxt;
  logic [A_W-1:0]      w_idx;
  logic                w_found;
  logic                w_single;
  logic                w_emit;

  find_first_set #(
    .NUM_WIRE (NUM_WIRE)
  ) u_ffs (
    .vec_i    (r_pending),
    .idx_o    (w_idx),
    .found_o  (w_found),
    .single_o (w_single)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // A zero vector is accepted in IDLE but never leaves IDLE.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    unique case (r_state)
      IDLE: begin
        if (d_valid_i && (d_i != '0)) begin
          w_pending_nxt = d_i;
          w_state_nxt   = EMIT;
        end
      end
      EMIT: begin
        if (a_ready_i) begin
          w_pending_nxt = r_pending & ~(NUM_WIRE'(1) << w_idx);
          if (w_single) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_pending_nxt = '0;
      end
    endcase
  end

  assign w_emit    = (r_state == EMIT);
  assign d_ready_o = (r_state == IDLE) && !rst_i;
  assign a_valid_o = w_emit;
  assign busy_o    = w_emit;
  assign a_o       = w_emit ? w_idx : '0;
  assign a_last_o  = w_emit && w_single;

  a_last_matches_popcount : assert property (@(posedge clk_i) disable iff (rst_i)
    w_emit |-> (a_last_o == (popcount(256'(r_pending)) == 1)));

  emit_has_pending : assert property (@(posedge clk_i) disable iff (rst_i)
    w_emit |-> (w_found && (int'(a_o) < NUM_WIRE)));

endmodule
`default_nettype wire

// File: doc/onehot_stream_encoder.md
Name: onehot_stream_encoder

Overview:
- Inverse of the team's combinational decoder: accepts a NUM_WIRE-bit request vector and emits the binary index of every set bit.
- Indices go out one per handshake, lowest index first, as a valid/ready stream.
- Each output index can be fed straight into the decoder's address/valid port; OR-ing the decoded words of one burst reproduces the captured vector.
- Sits between request-collecting logic and any index-driven consumer (arbiter grant, register select).

Parameters:
- NUM_WIRE, 4, width of the input vector; legal range 2..256.
- A_W, $clog2(NUM_WIRE), width of an index. Derived localparam, not overridable.

Ports:
- clk_i  input  1  clock; all logic is rising-edge.
- rst_i  input  1  reset, synchronous, active-high.
- d_i  input  NUM_WIRE  request vector.
- d_valid_i  input  1  d_i is valid.
- d_ready_o  output  1  block can capture d_i.
- a_o  output  A_W  binary index of the current lowest pending bit.
- a_valid_o  output  1  a_o is valid.
- a_ready_i  input  1  consumer accepts a_o.
- a_last_o  output  1  a_o is the final index of the current vector.
- busy_o  output  1  state is EMIT.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - pending register cleared to 0; state set to IDLE.
  - a_valid_o=0, a_o=0, a_last_o=0, busy_o=0.
  - d_ready_o is forced to 0 while rst_i=1 and is 1 from the first cycle after reset deasserts.
  - Reset mid-burst discards all pending bits; no further index is emitted.
- State IDLE:
  - d_ready_o=1, a_valid_o=0.
  - Capture happens on an edge where d_valid_i & d_ready_o.
  - Capture with d_i != 0: pending <= d_i, state -> EMIT.
  - Capture with d_i == 0: vector is consumed, nothing is emitted, state stays IDLE.
- State EMIT:
  - d_ready_o=0; no overlap with the next vector.
  - a_valid_o=1 and busy_o=1.
  - a_o = index of the lowest set bit of pending.
  - a_last_o = 1 when pending has exactly one bit set.
  - On an edge with a_ready_i=1: that bit is cleared in pending.
  - If that bit was the last one: state -> IDLE.
  - On an edge with a_ready_i=0: all outputs hold, stable until accepted (AXI-style; a_valid_o never drops without a handshake).
- Timing:
  - Latency: vector captured at edge N gives first a_valid_o=1 in the cycle after edge N.
  - One index per cycle while a_ready_i=1.
  - A vector with k set bits occupies k EMIT cycles minimum.
  - d_ready_o returns to 1 in the cycle after the last handshake.
- Outputs are decoded only from registered state (pending, state); no combinational path from a_ready_i or d_valid_i to any output.
- Boundaries:
  - All bits set: emits 0..NUM_WIRE-1 in order, a_last_o on NUM_WIRE-1.
  - Only MSB set: single index NUM_WIRE-1 with a_last_o=1.
  - NUM_WIRE not a power of two: indices >= NUM_WIRE are never produced.
  - Inputs X while d_valid_i=0 must not affect state.

Decomposition:
- Package encoder_pkg holds:
  - typedef enum logic {IDLE, EMIT} enc_state_e.
  - A function that returns the population count, used by assertions and by the bench model.
- Sub-module find_first_set (combinational): parameter NUM_WIRE.
  - Input vec_i; outputs idx_o [A_W], found_o, single_o (exactly one bit set).
  - Instantiated once on pending.

Test Plan:
- NUM_WIRE=4, reset held 2 cycles then released:
  - During reset: d_ready_o=0, a_valid_o=0, a_o=0.
  - Cycle after release: d_ready_o=1.
- d_i=4'b1011, d_valid_i=1, a_ready_i=1:
  - Indices 0,1,3 emitted on three consecutive cycles; a_last_o only with 3.
  - d_ready_o=1 one cycle after the last handshake.
- d_i=4'b0110 with a_ready_i toggling 0,1,0,0,1:
  - a_o=1 holds through the stall, then a_o=2 holds through the stall.
  - No index dropped or duplicated.
- d_i=4'b0000 captured:
  - No a_valid_o pulse; d_ready_o stays 1.
  - A following d_i=4'b1000 emits only index 3 with a_last_o=1.
- d_i=4'b1111 and rst_i asserted after the index-1 handshake:
  - Next cycle a_valid_o=0 and d_ready_o=0.
  - After release, IDLE with pending=0.
- Round-trip, 100 random vectors:
  - a_o/a_valid_o drive the decoder (NUM_WIRE=4).
  - OR of the decoded outputs over each burst equals the captured vector.
  - Burst length equals its popcount; error count 0.
